axi4_duth_noc_cr_snd: RTL and testbench

Credit-based link sender: the upstream end of a NoC link whose receiver holds a `CR_MAX_CREDITS`-deep buffer and returns one credit per popped flit. It accepts flits over a valid/ready interface, spends one credit per flit sent, and absorbs credit updates from the receiver. It also checks head/body/tail/single framing and flags protocol violations. It is instantiated on every router output port and NI→NoC port configured with `FLOW_CONTROL_CREDITS`.

---
 rtl/axi4_duth_noc_cr_snd.sv | 201 ++++++++++++++++++++
 tb/tb_axi4_duth_noc_cr_snd.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_duth_noc_cr_snd.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_duth_noc_cr_snd
//  Description : Credit-based NoC link sender. Accepts flits on a
//                valid/ready interface and spends one credit per flit sent.
//                It takes back credits returned by the receiver and checks
//                head/body/tail/single framing. Sticky error flags report
//                credit over/underflow and framing violations.
//  Ports       :
//    clk         - clock
//    rst         - synchronous active-high reset
//    valid_in    - upstream flit valid
//    data_in     - upstream flit, type in bits [1:0] (00 H, 01 B, 10 S, 11 T)
//    ready_out   - at least one credit is available (0 while rst is high)
//    valid_out   - flit valid on the link
//    data_out    - flit on the link
//    cr_upd_in   - one credit returned this cycle
//    credits     - current credit count
//    err_ovf     - sticky: push with no credit, or credit return above max
//    err_frame   - sticky: flit framing violation
//  Revision    : 1.0 - initial release
// ============================================================================
module axi4_duth_noc_cr_snd #(
    parameter int DATA_WIDTH       = 32,
    parameter int CR_MAX_CREDITS   = 3,
    parameter int CR_REG_DATA      = 1,
    parameter int CR_REG_CR_UPD    = 0,
    parameter int PUSH_CHECK_READY = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  valid_in,
    input  logic [DATA_WIDTH-1:0]                 data_in,
    output logic                                  ready_out,
    output logic                                  valid_out,
    output logic [DATA_WIDTH-1:0]                 data_out,
    input  logic                                  cr_upd_in,
    output logic [$clog2(CR_MAX_CREDITS+1)-1:0]   credits,
    output logic                                  err_ovf,
    output logic                                  err_frame
);

    localparam int CNT_W = $clog2(CR_MAX_CREDITS + 1);

    localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(CR_MAX_CREDITS);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ZERO = '0;

    localparam logic [1:0] C_TYPE_H = 2'b00;
    localparam logic [1:0] C_TYPE_B = 2'b01;
    localparam logic [1:0] C_TYPE_S = 2'b10;
    localparam logic [1:0] C_TYPE_T = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             frm_q;
    logic             frm_d;
    state_t           state_q;
    state_t           state_d;
    logic             w_push;
    logic             w_upd;
    logic             w_frm_set;

    // ------------------------------------------------------------------------
    // Ready / push. Ready comes from the registered counter only; rst forces
    // it low so the upstream never sees a credit while the link is resetting.
    // ------------------------------------------------------------------------
    assign ready_out = ~rst & (cnt_q != C_ZERO);
    assign w_push    = (PUSH_CHECK_READY != 0) ? (valid_in & ready_out) : valid_in;

    // ------------------------------------------------------------------------
    // Credit update path: optional one-cycle register on the returned credit.
    // ------------------------------------------------------------------------
    generate
        if (CR_REG_CR_UPD != 0) begin : g_upd_reg
            logic upd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    upd_q <= 1'b0;
                end else begin
                    upd_q <= cr_upd_in;
                end
            end
            assign w_upd = upd_q;
        end else begin : g_upd_comb
            assign w_upd = cr_upd_in;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Credit counter. A push with no credit leaves the counter at zero even
    // if a credit arrives in the same cycle: that credit pays for the flit
    // that was already sent without one.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (w_push && (cnt_q == C_ZERO)) begin
            ovf_d = 1'b1;
        end else if (w_push && !w_upd) begin
            cnt_d = cnt_q - C_ONE;
        end else if (!w_push && w_upd) begin
            if (cnt_q == C_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= C_MAX;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign credits = cnt_q;
    assign err_ovf = ovf_q;

    // ------------------------------------------------------------------------
    // Framing checker, advanced only on push. Violations are flagged but the
    // flit is still forwarded.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        w_frm_set = 1'b0;
        if (w_push) begin
            case (state_q)
                ST_IDLE: begin
                    case (data_in[1:0])
                        C_TYPE_H: state_d   = ST_PKT;
                        C_TYPE_S: state_d   = ST_IDLE;
                        default:  w_frm_set = 1'b1;
                    endcase
                end
                ST_PKT: begin
                    case (data_in[1:0])
                        C_TYPE_B: state_d   = ST_PKT;
                        C_TYPE_T: state_d   = ST_IDLE;
                        default:  w_frm_set = 1'b1;
                    endcase
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        frm_d = frm_q | w_frm_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frm_q   <= frm_d;
        end
    end

    assign err_frame = frm_q;

    // ------------------------------------------------------------------------
    // Link data path: registered or combinational passthrough.
    // ------------------------------------------------------------------------
    generate
        if (CR_REG_DATA != 0) begin : g_data_reg
            logic                  valid_q;
            logic [DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= w_push;
                    if (w_push) begin
                        data_q <= data_in;
                    end
                end
            end
            assign valid_out = valid_q;
            assign data_out  = data_q;
        end else begin : g_data_comb
            assign valid_out = w_push;
            assign data_out  = data_in;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_duth_noc_cr_snd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_duth_noc_cr_snd
//  Description : Self-checking bench for axi4_duth_noc_cr_snd. A default
//                instance is driven from a vector table; a second instance
//                (ready-checked push, registered credit return, combinational
//                data, 2 credits) is driven by a hand-written sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_duth_noc_cr_snd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid_in  = 1'b0;
    logic [31:0] data_in   = '0;
    logic        cr_upd_in = 1'b0;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic [1:0]  credits;
    logic        err_ovf;
    logic        err_frame;

    logic        a_valid_in  = 1'b0;
    logic [31:0] a_data_in   = '0;
    logic        a_cr_upd_in = 1'b0;
    logic        a_ready_out;
    logic        a_valid_out;
    logic [31:0] a_data_out;
    logic [1:0]  a_credits;
    logic        a_err_ovf;
    logic        a_err_frame;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi4_duth_noc_cr_snd #(
        .DATA_WIDTH      (32),
        .CR_MAX_CREDITS  (3),
        .CR_REG_DATA     (1),
        .CR_REG_CR_UPD   (0),
        .PUSH_CHECK_READY(0)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .ready_out(ready_out),
        .valid_out(valid_out),
        .data_out (data_out),
        .cr_upd_in(cr_upd_in),
        .credits  (credits),
        .err_ovf  (err_ovf),
        .err_frame(err_frame)
    );

    axi4_duth_noc_cr_snd #(
        .DATA_WIDTH      (32),
        .CR_MAX_CREDITS  (2),
        .CR_REG_DATA     (0),
        .CR_REG_CR_UPD   (1),
        .PUSH_CHECK_READY(1)
    ) u_alt (
        .clk      (clk),
        .rst      (rst),
        .valid_in (a_valid_in),
        .data_in  (a_data_in),
        .ready_out(a_ready_out),
        .valid_out(a_valid_out),
        .data_out (a_data_out),
        .cr_upd_in(a_cr_upd_in),
        .credits  (a_credits),
        .err_ovf  (a_err_ovf),
        .err_frame(a_err_frame)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        u;
        logic        evo;
        logic [31:0] edo;
        logic [1:0]  ecr;
        logic        erdy;
        logic        eovf;
        logic        efrm;
    } vec_t;

    vec_t tv[$];

    task automatic row(input logic r, input logic v, input logic [31:0] d,
                       input logic u, input logic evo, input logic [31:0] edo,
                       input logic [1:0] ecr, input logic erdy,
                       input logic eovf, input logic efrm);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.u = u;
        x.evo = evo; x.edo = edo; x.ecr = ecr;
        x.erdy = erdy; x.eovf = eovf; x.efrm = efrm;
        tv.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        //    r     v     data       upd   vo    data_out   cr    rdy   ovf   frm
        // reset state
        row(1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b0, 1'b0, 1'b0);
        // H,B,B drain all credits; T held by upstream
        row(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 2'd2, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h201, 1'b0, 1'b1, 32'h201, 2'd1, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h305, 1'b0, 1'b1, 32'h305, 2'd0, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h403, 1'b0, 1'b0, 32'h305, 2'd0, 1'b0, 1'b0, 1'b0);
        // credit return from zero, then the held T goes out
        row(1'b0, 1'b0, 32'h403, 1'b1, 1'b0, 32'h305, 2'd1, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h403, 1'b0, 1'b1, 32'h403, 2'd0, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h403, 2'd1, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h403, 2'd2, 1'b1, 1'b0, 1'b0);
        // push and credit in the same cycle: count unchanged
        row(1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h500, 2'd2, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h603, 1'b0, 1'b1, 32'h603, 2'd1, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h603, 2'd2, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h603, 2'd3, 1'b1, 1'b0, 1'b0);
        // extra credit at max: overflow, count saturates
        row(1'b0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h603, 2'd3, 1'b1, 1'b1, 1'b0);
        row(1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b1, 1'b0, 1'b0);
        // singles until empty, then push at zero (also with a credit)
        row(1'b0, 1'b1, 32'h012, 1'b0, 1'b1, 32'h012, 2'd2, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h022, 1'b0, 1'b1, 32'h022, 2'd1, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h032, 1'b0, 1'b1, 32'h032, 2'd0, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h042, 1'b0, 1'b1, 32'h042, 2'd0, 1'b0, 1'b1, 1'b0);
        row(1'b0, 1'b1, 32'h052, 1'b1, 1'b1, 32'h052, 2'd0, 1'b0, 1'b1, 1'b0);
        row(1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b0, 1'b0, 1'b0);
        // framing S,B,H,H,T (credit returned each cycle)
        row(1'b0, 1'b1, 32'h0A2, 1'b1, 1'b1, 32'h0A2, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h0B1, 1'b1, 1'b1, 32'h0B1, 2'd3, 1'b1, 1'b0, 1'b1);
        row(1'b0, 1'b1, 32'h0C0, 1'b1, 1'b1, 32'h0C0, 2'd3, 1'b1, 1'b0, 1'b1);
        row(1'b0, 1'b1, 32'h0D0, 1'b1, 1'b1, 32'h0D0, 2'd3, 1'b1, 1'b0, 1'b1);
        row(1'b0, 1'b1, 32'h0E3, 1'b1, 1'b1, 32'h0E3, 2'd3, 1'b1, 1'b0, 1'b1);
        row(1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b0, 1'b0, 1'b0);
        // legal H,B,T,S,H; then reset mid-packet and a B must be flagged
        row(1'b0, 1'b1, 32'h110, 1'b1, 1'b1, 32'h110, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h121, 1'b1, 1'b1, 32'h121, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h133, 1'b1, 1'b1, 32'h133, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h142, 1'b1, 1'b1, 32'h142, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h150, 1'b1, 1'b1, 32'h150, 2'd3, 1'b1, 1'b0, 1'b0);
        row(1'b1, 1'b0, 32'h000, 1'b0, 1'b0, 32'h000, 2'd3, 1'b0, 1'b0, 1'b0);
        row(1'b0, 1'b1, 32'h161, 1'b1, 1'b1, 32'h161, 2'd3, 1'b1, 1'b0, 1'b1);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst       = tv[i].r;
            valid_in  = tv[i].v;
            data_in   = tv[i].d;
            cr_upd_in = tv[i].u;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(tv[i].evo));
            chk($sformatf("row%0d data_out", i),  data_out,       tv[i].edo);
            chk($sformatf("row%0d credits", i),   32'(credits),   32'(tv[i].ecr));
            chk($sformatf("row%0d ready_out", i), 32'(ready_out), 32'(tv[i].erdy));
            chk($sformatf("row%0d err_ovf", i),   32'(err_ovf),   32'(tv[i].eovf));
            chk($sformatf("row%0d err_frame", i), 32'(err_frame), 32'(tv[i].efrm));
        end

        // ---------------- alternate configuration, hand sequence ----------
        @(negedge clk);
        rst = 1'b1; valid_in = 1'b0; cr_upd_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("main ready first cycle after reset", 32'(ready_out), 32'd1);
        chk("alt ready first cycle after reset",  32'(a_ready_out), 32'd1);
        chk("alt credits after reset",            32'(a_credits), 32'd2);

        // H: combinational forward
        a_valid_in = 1'b1; a_data_in = 32'hA0;
        #1;
        chk("alt H valid_out", 32'(a_valid_out), 32'd1);
        chk("alt H data_out",  a_data_out, 32'hA0);
        @(posedge clk); #1;
        chk("alt credits after H", 32'(a_credits), 32'd1);

        // T: last credit
        @(negedge clk);
        a_data_in = 32'hB3;
        #1;
        chk("alt T valid_out", 32'(a_valid_out), 32'd1);
        @(posedge clk); #1;
        chk("alt credits after T", 32'(a_credits), 32'd0);
        chk("alt ready after T",   32'(a_ready_out), 32'd0);

        // S offered with no credit: not pushed
        @(negedge clk);
        a_data_in = 32'hC2;
        #1;
        chk("alt blocked valid_out", 32'(a_valid_out), 32'd0);
        chk("alt blocked data_out",  a_data_out, 32'hC2);
        @(posedge clk); #1;
        chk("alt blocked credits", 32'(a_credits), 32'd0);
        chk("alt blocked err_ovf", 32'(a_err_ovf), 32'd0);

        // registered credit return: two cycles to ready
        @(negedge clk);
        a_valid_in = 1'b0; a_cr_upd_in = 1'b1;
        @(posedge clk); #1;
        chk("alt credits 1 cycle after upd", 32'(a_credits), 32'd0);
        chk("alt ready 1 cycle after upd",   32'(a_ready_out), 32'd0);
        @(negedge clk);
        a_cr_upd_in = 1'b0;
        @(posedge clk); #1;
        chk("alt credits 2 cycles after upd", 32'(a_credits), 32'd1);
        chk("alt ready 2 cycles after upd",   32'(a_ready_out), 32'd1);

        // credit update in flight across reset is discarded
        @(negedge clk);
        a_cr_upd_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("alt credits in reset", 32'(a_credits), 32'd2);
        chk("alt ready in reset",   32'(a_ready_out), 32'd0);
        @(negedge clk);
        rst = 1'b0; a_cr_upd_in = 1'b0;
        @(posedge clk); #1;
        chk("alt credits after discarded upd", 32'(a_credits), 32'd2);
        chk("alt err_ovf after discarded upd", 32'(a_err_ovf), 32'd0);
        chk("alt err_frame clean",             32'(a_err_frame), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
